// File: rtl/axi_lite_mbox_initiator.sv
// AXI-Lite single-outstanding initiator for mailbox register access.
// Turns one command into one AW/W or AR transaction, with a B/R timeout and drain of late beats.
module axi_lite_mbox_initiator #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_resp_o,
  output logic        rsp_timeout_o,
  output logic [31:0] m_aw_addr_o,
  output logic        m_aw_valid_o,
  input  logic        m_aw_ready_i,
  output logic [31:0] m_w_data_o,
  output logic [3:0]  m_w_strb_o,
  output logic        m_w_valid_o,
  input  logic        m_w_ready_i,
  input  logic [1:0]  m_b_resp_i,
  input  logic        m_b_valid_i,
  output logic        m_b_ready_o,
  output logic [31:0] m_ar_addr_o,
  output logic        m_ar_valid_o,
  input  logic        m_ar_ready_i,
  input  logic [31:0] m_r_data_i,
  input  logic [1:0]  m_r_resp_i,
  input  logic        m_r_valid_i,
  output logic        m_r_ready_o
);
  typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD, WAIT_R, RSP, DRAIN_B, DRAIN_R} state_t;

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [15:0] cnt_q, cnt_d;
  logic        drain_q, drain_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rdata_d;
  logic [1:0]  resp_d;
  logic        timeout_d;
  logic        cmd_ready_d, aw_valid_d, w_valid_d, b_ready_d, ar_valid_d, r_ready_d, rsp_valid_d;
  logic        cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  assign cmd_hs = cmd_valid_i & cmd_ready_o;
  assign aw_hs  = m_aw_valid_o & m_aw_ready_i;
  assign w_hs   = m_w_valid_o & m_w_ready_i;
  assign b_hs   = m_b_valid_i & m_b_ready_o;
  assign ar_hs  = m_ar_valid_o & m_ar_ready_i;
  assign r_hs   = m_r_valid_i & m_r_ready_o;
  assign rsp_hs = rsp_valid_o & rsp_ready_i;

  assign m_aw_addr_o = addr_q;
  assign m_ar_addr_o = addr_q;
  assign m_w_data_o  = wdata_q;
  assign m_w_strb_o  = 4'hF;

  // State register plus registered copies of every handshake output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cnt_q         <= '0;
      drain_q       <= 1'b0;
      cmd_ready_o   <= 1'b1;
      m_aw_valid_o  <= 1'b0;
      m_w_valid_o   <= 1'b0;
      m_b_ready_o   <= 1'b0;
      m_ar_valid_o  <= 1'b0;
      m_r_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_resp_o    <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      cmd_ready_o   <= cmd_ready_d;
      m_aw_valid_o  <= aw_valid_d;
      m_w_valid_o   <= w_valid_d;
      m_b_ready_o   <= b_ready_d;
      m_ar_valid_o  <= ar_valid_d;
      m_r_ready_o   <= r_ready_d;
      rsp_valid_o   <= rsp_valid_d;
      rsp_rdata_o   <= rdata_d;
      rsp_resp_o    <= resp_d;
      rsp_timeout_o <= timeout_d;
    end
  end

  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rsp_rdata_o;
    resp_d    = rsp_resp_o;
    timeout_d = rsp_timeout_o;
    unique case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          we_d      = cmd_we_i;
          addr_d    = cmd_addr_i;
          wdata_d   = cmd_wdata_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_we_i ? WR : RD;
        end
      end
      WR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = WAIT_B;
          cnt_d   = '0;
        end
      end
      RD: begin
        if (ar_hs) begin
          state_d = WAIT_R;
          cnt_d   = '0;
        end
      end
      WAIT_B, WAIT_R: begin
        // A beat arriving on the limit cycle still wins over the timeout
        if ((state_q == WAIT_B) ? b_hs : r_hs) begin
          state_d   = RSP;
          resp_d    = (state_q == WAIT_B) ? m_b_resp_i : m_r_resp_i;
          rdata_d   = (state_q == WAIT_B) ? 32'd0 : m_r_data_i;
          timeout_d = 1'b0;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d   = RSP;
          resp_d    = 2'b10;
          rdata_d   = 32'd0;
          timeout_d = 1'b1;
          drain_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RSP: begin
        if (rsp_hs) begin
          if (drain_q) state_d = we_q ? DRAIN_B : DRAIN_R;
          else         state_d = IDLE;
        end
      end
      DRAIN_B: begin
        if (b_hs) begin
          state_d = IDLE;
          drain_d = 1'b0;
        end
      end
      DRAIN_R: begin
        if (r_hs) begin
          state_d = IDLE;
          drain_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    aw_valid_d  = (state_d == WR) && !aw_done_d;
    w_valid_d   = (state_d == WR) && !w_done_d;
    ar_valid_d  = (state_d == RD);
    b_ready_d   = (state_d == WAIT_B) || (state_d == DRAIN_B);
    r_ready_d   = (state_d == WAIT_R) || (state_d == DRAIN_R);
    rsp_valid_d = (state_d == RSP);
  end

endmodule

// File: tb/tb_axi_lite_mbox_initiator.sv
// Scoreboard bench: stimulus queues a slave plan and an expected response per command;
// an AXI slave model and a response monitor check the DUT independently.
module tb_axi_lite_mbox_initiator;
  localparam int T = 4;

  logic        clk;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_timeout_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_resp_o;
  logic [31:0] m_aw_addr_o, m_w_data_o, m_ar_addr_o, m_r_data_i;
  logic        m_aw_valid_o, m_aw_ready_i, m_w_valid_o, m_w_ready_i;
  logic [3:0]  m_w_strb_o;
  logic [1:0]  m_b_resp_i, m_r_resp_i;
  logic        m_b_valid_i, m_b_ready_o, m_ar_valid_o, m_ar_ready_i, m_r_valid_i, m_r_ready_o;

  axi_lite_mbox_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_resp_o(rsp_resp_o), .rsp_timeout_o(rsp_timeout_o),
    .m_aw_addr_o(m_aw_addr_o), .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i),
    .m_w_data_o(m_w_data_o), .m_w_strb_o(m_w_strb_o), .m_w_valid_o(m_w_valid_o),
    .m_w_ready_i(m_w_ready_i),
    .m_b_resp_i(m_b_resp_i), .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o),
    .m_ar_addr_o(m_ar_addr_o), .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i),
    .m_r_data_i(m_r_data_i), .m_r_resp_i(m_r_resp_i), .m_r_valid_i(m_r_valid_i),
    .m_r_ready_o(m_r_ready_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, rdata;
    logic [1:0]  resp;
    int          d;
    int          mode;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        timeout;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    rsp_stall = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // AXI slave: beat delay d counts cycles after the address phase completes; d >= T means timeout
  initial begin : slave
    plan_t p;
    bit have, aw_seen, w_seen, ar_seen, active, beat, rst_seen;
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_hold, w_hold, ar_hold;
    logic [31:0] aw_a, w_d, ar_a;
    int since, wl;
    {aw_seen, w_seen, ar_seen, active, beat} = '0;
    since = 0; wl = 0;
    m_aw_ready_i = 0; m_w_ready_i = 0; m_ar_ready_i = 0;
    m_b_valid_i = 0; m_b_resp_i = 0; m_r_valid_i = 0; m_r_resp_i = 0; m_r_data_i = 0;
    forever begin
      @(negedge clk);
      have = plan_q.size() != 0;
      if (have) p = plan_q[0];
      aw_hs = m_aw_valid_o && m_aw_ready_i;
      w_hs  = m_w_valid_o && m_w_ready_i;
      ar_hs = m_ar_valid_o && m_ar_ready_i;
      b_hs  = m_b_valid_i && m_b_ready_o;
      r_hs  = m_r_valid_i && m_r_ready_o;
      aw_hold = m_aw_valid_o && !m_aw_ready_i; aw_a = m_aw_addr_o;
      w_hold  = m_w_valid_o && !m_w_ready_i;   w_d  = m_w_data_o;
      ar_hold = m_ar_valid_o && !m_ar_ready_i; ar_a = m_ar_addr_o;
      if (m_aw_valid_o) begin
        chk("aw_expected", 32'(have && p.we && !aw_seen), 1);
        if (have) chk("aw_addr", m_aw_addr_o, p.addr);
      end
      if (m_w_valid_o) begin
        chk("w_expected", 32'(have && p.we && !w_seen), 1);
        if (have) chk("w_data", m_w_data_o, p.wdata);
        chk("w_strb", 32'(m_w_strb_o), 32'hF);
      end
      if (m_ar_valid_o) begin
        chk("ar_expected", 32'(have && !p.we && !ar_seen), 1);
        if (have) chk("ar_addr", m_ar_addr_o, p.addr);
      end
      @(posedge clk);
      rst_seen = rst_i;
      #1;
      if (rst_seen) begin
        plan_q.delete();
        {aw_seen, w_seen, ar_seen, active, beat} = '0;
        m_aw_ready_i = 0; m_w_ready_i = 0; m_ar_ready_i = 0;
        m_b_valid_i = 0; m_r_valid_i = 0;
      end else begin
        if (aw_hold) begin
          chk("aw_valid_held", 32'(m_aw_valid_o), 1);
          chk("aw_addr_stable", m_aw_addr_o, aw_a);
        end
        if (w_hold) begin
          chk("w_valid_held", 32'(m_w_valid_o), 1);
          chk("w_data_stable", m_w_data_o, w_d);
        end
        if (ar_hold) begin
          chk("ar_valid_held", 32'(m_ar_valid_o), 1);
          chk("ar_addr_stable", m_ar_addr_o, ar_a);
        end
        if (aw_hs) begin aw_seen = 1; wl = 0; end
        else if (aw_seen) wl++;
        if (w_hs) w_seen = 1;
        if (ar_hs) ar_seen = 1;
        if (b_hs || r_hs) begin
          if (p.d >= T) chk("cmd_ready_after_drain", 32'(cmd_ready_o), 1);
          else chk("rsp_valid_after_beat", 32'(rsp_valid_o), 1);
          void'(plan_q.pop_front());
          {aw_seen, w_seen, ar_seen, active, beat} = '0;
          m_b_valid_i = 0; m_r_valid_i = 0;
        end else if (active) begin
          since++;
        end else if (have && ((p.we && aw_seen && w_seen) || (!p.we && ar_seen))) begin
          active = 1; since = 0;
        end
        if (active) begin
          if (!beat && since == p.d) begin
            beat = 1;
            if (p.we) begin m_b_valid_i = 1; m_b_resp_i = p.resp; end
            else begin m_r_valid_i = 1; m_r_resp_i = p.resp; m_r_data_i = p.rdata; end
          end
          if (since < T) chk("ready_while_waiting", 32'(p.we ? m_b_ready_o : m_r_ready_o), 1);
          if (since == T && p.d >= T) begin
            chk("timeout_rsp_valid", 32'(rsp_valid_o), 1);
            chk("timeout_ready_dropped", 32'(p.we ? m_b_ready_o : m_r_ready_o), 0);
          end
        end
        have = plan_q.size() != 0;
        if (have) p = plan_q[0];
        if (have && p.mode == 1) begin
          m_aw_ready_i = 1; m_w_ready_i = 1; m_ar_ready_i = 1;
        end else if (have && p.mode == 2) begin
          m_aw_ready_i = 1; m_w_ready_i = aw_seen && (wl >= 5); m_ar_ready_i = 1;
        end else begin
          m_aw_ready_i = ($urandom_range(0, 2) != 0);
          m_w_ready_i  = ($urandom_range(0, 2) != 0);
          m_ar_ready_i = ($urandom_range(0, 2) != 0);
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every rsp handshake and checks payload stability
  initial begin : monitor
    exp_t e;
    bit seen, pending;
    logic [31:0] s_rd;
    logic [1:0]  s_rs;
    logic        s_to;
    int n, want;
    seen = 0; pending = 0; n = 0; want = 0;
    rsp_ready_i = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid_o) begin
        if (seen) begin
          chk("rsp_rdata_stable", rsp_rdata_o, s_rd);
          chk("rsp_resp_stable", 32'(rsp_resp_o), 32'(s_rs));
          chk("rsp_timeout_stable", 32'(rsp_timeout_o), 32'(s_to));
        end else begin
          seen = 1; s_rd = rsp_rdata_o; s_rs = rsp_resp_o; s_to = rsp_timeout_o;
        end
        if (rsp_ready_i) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid_o), 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata_o, e.rdata);
            chk("rsp_resp", 32'(rsp_resp_o), 32'(e.resp));
            chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e.timeout));
          end
          seen = 0;
        end
      end else seen = 0;
      @(posedge clk);
      #1;
      if (rsp_valid_o) begin
        if (!pending) begin
          pending = 1; n = 0;
          want = (rsp_stall >= 0) ? rsp_stall : int'($urandom_range(0, 3));
        end else n++;
        rsp_ready_i = (n >= want);
      end else begin
        pending = 0;
        rsp_ready_i = ($urandom_range(0, 1) != 0);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic [1:0] resp, input int d,
                       input int mode);
    plan_t p;
    exp_t  e;
    bit    hs;
    p.we = we; p.addr = addr; p.wdata = wdata; p.rdata = rdata;
    p.resp = resp; p.d = d; p.mode = mode;
    plan_q.push_back(p);
    e.timeout = (d >= T);
    e.resp    = e.timeout ? 2'b10 : resp;
    e.rdata   = (!we && !e.timeout) ? rdata : 32'd0;
    exp_q.push_back(e);
    cmd_valid_i = 1; cmd_we_i = we; cmd_addr_i = addr;
    cmd_wdata_i = we ? wdata : $urandom();
    hs = 0;
    for (int i = 0; i < 4000 && !hs; i++) begin
      @(negedge clk);
      hs = cmd_ready_o;
      @(posedge clk);
      #1;
    end
    cmd_valid_i = 0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL cmd_accept: got no handshake, want handshake");
    end else begin
      chk("cmd_ready_after_accept", 32'(cmd_ready_o), 0);
      if (we) begin
        chk("aw_valid_first_cycle", 32'(m_aw_valid_o), 1);
        chk("w_valid_first_cycle", 32'(m_w_valid_o), 1);
      end else chk("ar_valid_first_cycle", 32'(m_ar_valid_o), 1);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = (plan_q.size() == 0) && (exp_q.size() == 0) && cmd_ready_o;
    end
    chk("wait_idle", 32'(ok), 1);
  endtask

  initial begin : stimulus
    rst_i = 1; cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = 0; cmd_wdata_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready_o), 1);
    chk("reset_valids", 32'({m_aw_valid_o, m_w_valid_o, m_ar_valid_o, rsp_valid_o}), 0);
    chk("reset_readies", 32'({m_b_ready_o, m_r_ready_o}), 0);
    chk("reset_payload", 32'({rsp_rdata_o != 0, rsp_resp_o, rsp_timeout_o}), 0);
    rst_i = 0;
    @(posedge clk);
    #1;
    chk("idle_cmd_ready", 32'(cmd_ready_o), 1);

    issue(1, 32'h1040_2000, 32'hDEAD_BEEF, 32'd0, 2'b00, 0, 1);
    issue(1, 32'h1040_2004, 32'hCAFE_0001, 32'd0, 2'b00, 1, 2);
    wait_idle();
    rsp_stall = 3;
    issue(0, 32'h1040_3000, 32'd0, 32'h1234_5678, 2'b10, 2, 1);
    wait_idle();
    rsp_stall = -1;
    issue(0, 32'h1040_3004, 32'd0, 32'hAAAA_5555, 2'b00, T + 3, 1);
    issue(1, 32'h1040_2008, 32'h0BAD_F00D, 32'd0, 2'b11, T - 1, 0);
    issue(0, 32'h1040_300C, 32'd0, 32'h0F0F_F0F0, 2'b01, T - 1, 0);
    issue(1, 32'h1040_200C, 32'h1357_9BDF, 32'd0, 2'b00, T, 0);
    wait_idle();

    for (int k = 0; k < 40; k++) begin
      issue(($urandom_range(0, 1) != 0),
            {16'h1040, 4'h0, 10'($urandom_range(0, 1023)), 2'b00},
            $urandom(), $urandom(), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, T + 3)), int'($urandom_range(0, 1)));
    end
    wait_idle();

    issue(1, 32'h1040_2010, 32'h5555_AAAA, 32'd0, 2'b00, T - 1, 1);
    for (int i = 0; i < 50 && !m_b_ready_o; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reached_wait_b", 32'(m_b_ready_o), 1);
    rst_i = 1;
    @(posedge clk);
    #1;
    rst_i = 0;
    void'(exp_q.pop_back());
    chk("midreset_cmd_ready", 32'(cmd_ready_o), 1);
    chk("midreset_b_ready", 32'(m_b_ready_o), 0);
    chk("midreset_valids", 32'({m_aw_valid_o, m_w_valid_o, rsp_valid_o}), 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("midreset_no_rsp", 32'(rsp_valid_o), 0);
    end

    issue(0, 32'h1040_3010, 32'd0, 32'h8765_4321, 2'b00, 1, 0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
